fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 8'h00, giving the program counter value loaded on reset.
REQ-002 The block SHALL have a parameter WIDE_BIT, default 7, giving the opcode bit that marks a two-byte instruction.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_addr, output, 8 bits: the read address to the program memory.
REQ-006 The block SHALL have port mem_we, output, 1 bit: the memory write enable, tied to 0.
REQ-007 The block SHALL have port mem_rdata, input, 8 bits: the memory read data, combinational from mem_addr in the same cycle.
REQ-008 The block SHALL have port instr_valid, output, 1 bit: a complete instruction is presented.
REQ-009 The block SHALL have port instr_ready, input, 1 bit: the decoder accepts the instruction.
REQ-010 The block SHALL have port instr_opcode, output, 8 bits: the fetched opcode.
REQ-011 The block SHALL have port instr_operand, output, 8 bits: the fetched operand, or 8'h00 for a one-byte instruction.
REQ-012 The block SHALL have port instr_pc, output, 8 bits: the address of the opcode byte.
REQ-013 The block SHALL have port jump_en, input, 1 bit: redirect request.
REQ-014 The block SHALL have port jump_addr, input, 8 bits: the redirect target.
REQ-015 The block SHALL have port halt, input, 1 bit: stop fetching.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH_OP, FETCH_ARG and HOLD, with an 8-bit program counter pc.
REQ-017 The block SHALL drive mem_addr = pc in every state.
REQ-018 In FETCH_OP, the block SHALL capture mem_rdata into instr_opcode and instr_pc <= pc, and set pc <= pc+1.
REQ-019 From FETCH_OP, the block SHALL go to FETCH_ARG if mem_rdata[WIDE_BIT]=1; otherwise it SHALL clear instr_operand and go to HOLD.
REQ-020 In FETCH_ARG, the block SHALL capture mem_rdata into instr_operand, set pc <= pc+1, and go to HOLD.
REQ-021 The block SHALL assert instr_valid only in HOLD.
REQ-022 Latency SHALL be 1 cycle (one-byte instruction) or 2 cycles (two-byte instruction) from entering FETCH_OP to instr_valid=1.
REQ-023 The instr_opcode, instr_operand and instr_pc outputs SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-024 In HOLD with instr_ready=1, the block SHALL go to FETCH_OP, or to IDLE if halt=1.
REQ-025 When jump_en=1 in any state, the block SHALL set pc <= jump_addr and go to FETCH_OP; any partially fetched or held instruction is discarded, and instr_valid is 0 the next cycle.
REQ-026 jump_en SHALL have priority over halt, and over acceptance of a held instruction.
REQ-027 halt=1 in FETCH_OP SHALL send the block to IDLE without a capture and leave pc unchanged.
REQ-028 halt=1 in FETCH_ARG SHALL NOT interrupt the instruction; it takes effect at acceptance in HOLD.
REQ-029 In IDLE with halt=0, the block SHALL go to FETCH_OP.
REQ-030 pc increments SHALL wrap 8'hFF -> 8'h00, including between the opcode and operand bytes.

Reset
REQ-031 While rst_n=0, the block SHALL hold state=FETCH_OP, pc=RESET_PC, instr_valid=0, instr_opcode=8'h00, instr_operand=8'h00 and instr_pc=8'h00, independent of clk.
REQ-032 Reset asserted mid-fetch or in HOLD SHALL discard the instruction immediately.
REQ-033 The first capture after reset release SHALL occur on the first rising clk edge with rst_n=1.

Structure
REQ-034 A shared cpu package SHALL hold the fetch state enumeration, the 8-bit address/data width constants and the default RESET_PC.
REQ-035 No sub-module SHALL be required; the block SHALL connect directly to the existing 256x8 memory with mem_we=0.

Verification
REQ-036 Verification SHALL cover a one-byte fetch: mem[00]=8'h12, ready=1 -> valid in cycle 2, opcode=12, operand=00, instr_pc=00, next fetch at address 01.
REQ-037 Verification SHALL cover a two-byte fetch: mem[00]=8'h85, mem[01]=8'h3C -> valid after 2 fetch cycles, opcode=85, operand=3C, next fetch at address 02.
REQ-038 Verification SHALL cover backpressure: ready=0 for 5 cycles in HOLD -> outputs stable and pc unchanged; ready=1 -> advance.
REQ-039 Verification SHALL cover a jump during FETCH_ARG to 8'h40 -> no valid for the discarded instruction, next instr_pc=40.
REQ-040 Verification SHALL cover wrap: a two-byte opcode at address FF -> operand read from 00, instr_pc=FF, next fetch at 01.
REQ-041 Verification SHALL cover halt at acceptance -> IDLE with no memory-driven changes; halt released -> resume at the next sequential pc; rst_n pulse mid-HOLD -> valid drops asynchronously and pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, bus widths and the default reset PC.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_OP  = 2'd1,
        FETCH_ARG = 2'd2,
        HOLD      = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads one- or two-byte instructions from a 256x8 memory
// and presents them to the decoder with a valid/ready handshake.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                WIDE_BIT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] opcode_reg, opcode_next;
    logic [DATA_W-1:0] operand_reg, operand_next;
    logic [ADDR_W-1:0] ipc_reg, ipc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FETCH_OP;
            pc_reg      <= RESET_PC;
            opcode_reg  <= '0;
            operand_reg <= '0;
            ipc_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            opcode_reg  <= opcode_next;
            operand_reg <= operand_next;
            ipc_reg     <= ipc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        opcode_next  = opcode_reg;
        operand_next = operand_reg;
        ipc_next     = ipc_reg;

        // A redirect wins over everything, including a pending handshake.
        if (jump_en) begin
            pc_next    = jump_addr;
            state_next = FETCH_OP;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (!halt) state_next = FETCH_OP;
                end
                FETCH_OP: begin
                    if (halt) begin
                        state_next = IDLE;
                    end else begin
                        opcode_next = mem_rdata;
                        ipc_next    = pc_reg;
                        pc_next     = pc_reg + 8'd1;
                        if (mem_rdata[WIDE_BIT]) begin
                            state_next = FETCH_ARG;
                        end else begin
                            operand_next = '0;
                            state_next   = HOLD;
                        end
                    end
                end
                FETCH_ARG: begin
                    // halt is deferred to acceptance so the instruction completes.
                    operand_next = mem_rdata;
                    pc_next      = pc_reg + 8'd1;
                    state_next   = HOLD;
                end
                HOLD: begin
                    if (instr_ready) state_next = halt ? IDLE : FETCH_OP;
                end
                default: state_next = FETCH_OP;
            endcase
        end
    end

    assign mem_addr      = pc_reg;
    assign mem_we        = 1'b0;
    assign instr_valid   = (state_reg == HOLD);
    assign instr_opcode  = opcode_reg;
    assign instr_operand = operand_reg;
    assign instr_pc      = ipc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs, expected instructions
// queued by the stimulus and checked by a monitor on each accepted handshake.
module tb_fetch_unit;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
        logic [7:0] pc;
    } instr_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       halt;

    logic [7:0] mem [256];
    instr_t     exp_q [$];
    int         vectors = 0;
    int         fails   = 0;

    assign mem_rdata = mem[mem_addr];

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_operand(instr_operand),
        .instr_pc     (instr_pc),
        .jump_en      (jump_en),
        .jump_addr    (jump_addr),
        .halt         (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted instruction must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_instr: got op=%02h arg=%02h pc=%02h, expected none",
                         instr_opcode, instr_operand, instr_pc);
            end else begin
                instr_t e;
                e = exp_q.pop_front();
                $display("accept op=%02h arg=%02h pc=%02h (exp %02h %02h %02h)",
                         instr_opcode, instr_operand, instr_pc, e.opcode, e.operand, e.pc);
                check("acc_opcode", instr_opcode, e.opcode);
                check("acc_operand", instr_operand, e.operand);
                check("acc_pc", instr_pc, e.pc);
            end
        end
    end

    function automatic instr_t mk(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] pc);
        instr_t r;
        r.opcode  = op;
        r.operand = arg;
        r.pc      = pc;
        return r;
    endfunction

    // Asserts reset mid-cycle and checks the asynchronous effect before any edge.
    task automatic assert_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid", {7'd0, instr_valid}, 8'h00);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_opcode", instr_opcode, 8'h00);
        check("rst_operand", instr_operand, 8'h00);
        check("rst_ipc", instr_pc, 8'h00);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 8'(n), 8'(exp_lat));
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        instr_ready = 1'b0;
        jump_en = 1'b0;
        jump_addr = 8'h00;
        halt = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // One-byte fetch.
        mem[8'h00] = 8'h12;
        assert_reset();
        check("mem_we", {7'd0, mem_we}, 8'h00);
        release_reset();
        wait_valid("lat_1byte", 1);
        exp_q.push_back(mk(8'h12, 8'h00, 8'h00));
        check("next_addr_1byte", mem_addr, 8'h01);
        accept();
        check("after_acc_addr", mem_addr, 8'h01);

        // Two-byte fetch, then backpressure.
        mem[8'h00] = 8'h85; mem[8'h01] = 8'h3C; mem[8'h02] = 8'h00;
        assert_reset();
        release_reset();
        wait_valid("lat_2byte", 2);
        exp_q.push_back(mk(8'h85, 8'h3C, 8'h00));
        check("next_addr_2byte", mem_addr, 8'h02);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {7'd0, instr_valid}, 8'h01);
            check("bp_opcode", instr_opcode, 8'h85);
            check("bp_operand", instr_operand, 8'h3C);
            check("bp_ipc", instr_pc, 8'h00);
            check("bp_addr", mem_addr, 8'h02);
            @(posedge clk);
            #1;
        end
        accept();
        wait_valid("lat_after_bp", 1);
        exp_q.push_back(mk(8'h00, 8'h00, 8'h02));
        accept();

        // Jump during FETCH_ARG discards the partial instruction.
        mem[8'h00] = 8'h85; mem[8'h40] = 8'h21;
        assert_reset();
        release_reset();
        @(posedge clk);
        #1;
        check("jmp_arg_valid", {7'd0, instr_valid}, 8'h00);
        jump_en = 1'b1;
        jump_addr = 8'h40;
        @(posedge clk);
        #1;
        jump_en = 1'b0;
        check("jmp_valid_drop", {7'd0, instr_valid}, 8'h00);
        check("jmp_addr", mem_addr, 8'h40);
        wait_valid("lat_after_jmp", 1);
        exp_q.push_back(mk(8'h21, 8'h00, 8'h40));
        accept();

        // Two-byte opcode at FF wraps its operand fetch to 00.
        mem[8'hFF] = 8'h9A; mem[8'h00] = 8'h5B; mem[8'h01] = 8'h33; mem[8'h02] = 8'h00;
        assert_reset();
        jump_en = 1'b1;
        jump_addr = 8'hFF;
        release_reset();
        @(posedge clk);
        #1;
        jump_en = 1'b0;
        check("wrap_jmp_addr", mem_addr, 8'hFF);
        wait_valid("lat_wrap", 2);
        exp_q.push_back(mk(8'h9A, 8'h5B, 8'hFF));
        check("wrap_next_addr", mem_addr, 8'h01);

        // Halt at acceptance parks in IDLE; release resumes sequentially.
        halt = 1'b1;
        accept();
        for (int i = 0; i < 3; i++) begin
            check("idle_valid", {7'd0, instr_valid}, 8'h00);
            check("idle_addr", mem_addr, 8'h01);
            check("idle_opcode", instr_opcode, 8'h9A);
            @(posedge clk);
            #1;
        end
        halt = 1'b0;
        wait_valid("lat_resume", 2);
        exp_q.push_back(mk(8'h33, 8'h00, 8'h01));
        accept();
        wait_valid("lat_pre_rst", 1);
        check("pre_rst_valid", {7'd0, instr_valid}, 8'h01);
        assert_reset();

        // Halt in FETCH_OP stops without capture; halt in FETCH_ARG completes.
        mem[8'h00] = 8'h85; mem[8'h01] = 8'h3C;
        halt = 1'b1;
        release_reset();
        @(posedge clk);
        #1;
        check("halt_op_valid", {7'd0, instr_valid}, 8'h00);
        check("halt_op_addr", mem_addr, 8'h00);
        check("halt_op_opcode", instr_opcode, 8'h00);
        halt = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("halt_arg_pre", {7'd0, instr_valid}, 8'h00);
        halt = 1'b1;
        wait_valid("lat_halt_arg", 1);
        exp_q.push_back(mk(8'h85, 8'h3C, 8'h00));
        accept();
        check("halt_acc_valid", {7'd0, instr_valid}, 8'h00);
        check("halt_acc_addr", mem_addr, 8'h02);
        @(posedge clk);
        #1;
        check("halt_idle_valid", {7'd0, instr_valid}, 8'h00);
        halt = 1'b0;

        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
